// File: rtl/relprime_engine.sv
`default_nettype none
// ============================================================================
// Module      : relprime_engine
// Description : Finds the smallest integer m >= 2 that is coprime with a
//               WIDTH-bit operand n, using a subtraction-based Euclid loop.
//               One Euclid step per clock.
//               When a candidate's gcd has been reduced (b == 0), the same
//               cycle either reports the candidate or reloads the next one.
//               A zero operand is flagged through err instead of being
//               searched.
//
// Ports       : CLK     - clock, rising edge
//               RST_N   - asynchronous active-low reset
//               start   - request, sampled only while idle
//               n       - operand, captured on the accepted start
//               busy    - high while the Euclid loop runs
//               done    - one-cycle pulse when result/err are valid
//               result  - smallest coprime m (0 on error), held until the
//                         next accepted start
//               err     - high when the operand was zero, held like result
//               cycles  - Euclid-cycle counter (RELPRIME_CYCLES_EN only)
//
// Options     : RELPRIME_CYCLES_EN - adds the 32-bit saturating cycles output
//
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module relprime_engine #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
`ifdef RELPRIME_CYCLES_EN
    ,
    output logic [31:0]      cycles
`endif
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_TWO = WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GCD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_n_q;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    logic [WIDTH-1:0] w_n_q_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_m_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_err_nxt;
    logic [WIDTH-1:0] w_m_inc;

    // m + 1 cannot wrap: n + 1 is always coprime with n, so the search stops
    // at or before m = n + 1, and the all-ones operand stops at m = 2.
    assign w_m_inc = r_m + c_ONE;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_n_q_nxt    = r_n_q;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_m_nxt      = r_m;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (n != '0) begin
                        w_n_q_nxt   = n;
                        w_a_nxt     = n;
                        w_b_nxt     = c_TWO;
                        w_m_nxt     = c_TWO;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = S_GCD;
                    end else begin
                        // gcd(0, m) = m, so no candidate could succeed.
                        w_result_nxt = '0;
                        w_err_nxt    = 1'b1;
                        w_state_nxt  = S_DONE;
                    end
                end
            end

            S_GCD: begin
                if (r_b == '0) begin
                    // a now holds gcd(n, m)
                    if (r_a == c_ONE) begin
                        w_result_nxt = r_m;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_m_nxt = w_m_inc;
                        w_a_nxt = r_n_q;
                        w_b_nxt = w_m_inc;
                    end
                end else if (r_a >= r_b) begin
                    w_a_nxt = r_a - r_b;
                end else begin
                    w_a_nxt = r_b;
                    w_b_nxt = r_a;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_n_q    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_n_q    <= w_n_q_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_m      <= w_m_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign busy   = (r_state == S_GCD);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign err    = r_err;

`ifdef RELPRIME_CYCLES_EN
    // ------------------------------------------------------------------------
    // Euclid-cycle counter: cleared on any accepted start (including the
    // zero-operand case), counts GCD cycles, sticks at all-ones.
    // ------------------------------------------------------------------------
    logic [31:0] r_cycles;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cycles <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_cycles <= '0;
        end else if ((r_state == S_GCD) && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign cycles = r_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_relprime_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_relprime_engine
// Description : Self-checking bench for relprime_engine (WIDTH = 16).
//               Vector table, hand-written corner sequences and random
//               operands are checked against an arithmetic reference model.
//               Build with RELPRIME_CYCLES_EN to also check the cycles port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relprime_engine;

    localparam int WIDTH = 16;
    localparam int LIMIT = 40000;

    logic             CLK;
    logic             RST_N;
    logic             start;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;
`ifdef RELPRIME_CYCLES_EN
    logic [31:0]      cycles;
`endif

    int vectors     = 0;
    int miscompares = 0;

    relprime_engine #(.WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .start  (start),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
`ifdef RELPRIME_CYCLES_EN
        ,
        .cycles (cycles)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic int unsigned gcd_mod(input int unsigned x, input int unsigned y);
        int unsigned a = x;
        int unsigned b = y;
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int unsigned model_result(input int unsigned nv);
        int unsigned m = 2;
        if (nv == 0) return 0;
        while (gcd_mod(nv, m) != 1) m++;
        return m;
    endfunction

    // Time spent busy: each candidate m costs one cycle per subtract-or-swap
    // step of Euclid's subtractive algorithm, plus one cycle to inspect the gcd.
    function automatic int model_cycles(input int unsigned nv);
        int          total = 0;
        int unsigned x;
        int unsigned y;
        int unsigned t;
        if (nv == 0) return 0;
        for (int unsigned m = 2; m <= nv + 1; m++) begin
            x = nv;
            y = m;
            while (y != 0) begin
                if (x >= y) x = x - y;
                else begin t = x; x = y; y = t; end
                total++;
            end
            total++;
            if (gcd_mod(nv, m) == 1) break;
        end
        return total;
    endfunction

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done. Sampling on the falling
    // edge; the operand is scrambled right after acceptance.
    task automatic do_op(input logic [WIDTH-1:0] nv,
                         output logic [WIDTH-1:0] res, output logic e,
                         output int bcnt, output bit gap, output bit to);
        bit got;
        res  = '0;
        e    = 1'b0;
        bcnt = 0;
        gap  = 1'b0;
        to   = 1'b0;
        got  = 1'b0;
        @(negedge CLK);
        start = 1'b1;
        n     = nv;
        @(negedge CLK);
        start = 1'b0;
        n     = WIDTH'($urandom);
        for (int i = 0; i < LIMIT && !got; i++) begin
            if (done) begin
                got = 1'b1;
                res = result;
                e   = err;
                if (busy) gap = 1'b1;
            end else begin
                if (busy) bcnt++;
                else gap = 1'b1;
                @(negedge CLK);
            end
        end
        if (!got) to = 1'b1;
    endtask

    task automatic run_and_check(input string tag, input logic [WIDTH-1:0] nv,
                                 input logic [WIDTH-1:0] exp_res, input logic exp_err);
        logic [WIDTH-1:0] res;
        logic             e;
        int               bcnt;
        bit               gap;
        bit               to;
        do_op(nv, res, e, bcnt, gap, to);
        check($sformatf("%s n=%0d timeout", tag, nv), 64'(to), 64'd0);
        check($sformatf("%s n=%0d result", tag, nv), 64'(res), 64'(exp_res));
        check($sformatf("%s n=%0d err", tag, nv), 64'(e), 64'(exp_err));
        check($sformatf("%s n=%0d busy_cycles", tag, nv), 64'(bcnt), 64'(model_cycles(32'(nv))));
        check($sformatf("%s n=%0d busy_shape", tag, nv), 64'(gap), 64'd0);
        @(negedge CLK);
        check($sformatf("%s n=%0d done_width", tag, nv), 64'(done), 64'd0);
        check($sformatf("%s n=%0d result_held", tag, nv), 64'(result), 64'(exp_res));
`ifdef RELPRIME_CYCLES_EN
        check($sformatf("%s n=%0d cycles", tag, nv), 64'(cycles), 64'(model_cycles(32'(nv))));
`endif
    endtask

    typedef struct {
        logic [WIDTH-1:0] nv;
        logic [WIDTH-1:0] res;
        logic             e;
    } vec_t;

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        vec_t tbl[7];
        int   dones;
        int   bsum;
        logic [WIDTH-1:0] rv;

        tbl[0] = '{nv: 16'd30,    res: 16'd7,  e: 1'b0};
        tbl[1] = '{nv: 16'd1,     res: 16'd2,  e: 1'b0};
        tbl[2] = '{nv: 16'd65535, res: 16'd2,  e: 1'b0};
        tbl[3] = '{nv: 16'd0,     res: 16'd0,  e: 1'b1};
        tbl[4] = '{nv: 16'd6,     res: 16'd5,  e: 1'b0};
        tbl[5] = '{nv: 16'd2310,  res: 16'd13, e: 1'b0};
        tbl[6] = '{nv: 16'd9,     res: 16'd2,  e: 1'b0};

        RST_N = 1'b0;
        start = 1'b0;
        n     = '0;
        repeat (3) @(negedge CLK);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset err", 64'(err), 64'd0);
`ifdef RELPRIME_CYCLES_EN
        check("reset cycles", 64'(cycles), 64'd0);
`endif
        RST_N = 1'b1;

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            run_and_check($sformatf("table[%0d]", i), tbl[i].nv, tbl[i].res, tbl[i].e);
        end

        // Zero operand: busy must never rise
        @(negedge CLK);
        start = 1'b1;
        n     = '0;
        @(negedge CLK);
        start = 1'b0;
        check("zero done_next_cycle", 64'(done), 64'd1);
        check("zero busy", 64'(busy), 64'd0);
        check("zero err", 64'(err), 64'd1);
        check("zero result", 64'(result), 64'd0);

        // start while busy is ignored
        @(negedge CLK);
        start = 1'b1;
        n     = 16'd210;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        start = 1'b1;
        n     = 16'd30;
        @(negedge CLK);
        start = 1'b0;
        dones = 0;
        bsum  = 4;
        for (int i = 0; i < LIMIT && dones == 0; i++) begin
            if (done) dones++;
            else begin
                if (busy) bsum++;
                @(negedge CLK);
            end
        end
        check("ignore result", 64'(result), 64'd11);
        check("ignore busy_cycles", 64'(bsum), 64'(model_cycles(210)));
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (done) dones++;
        end
        check("ignore single_done", 64'(dones), 64'd1);

        // Asynchronous reset in the middle of a computation
        @(negedge CLK);
        start = 1'b1;
        n     = 16'd2310;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        check("abort busy_before", 64'(busy), 64'd1);
        #2 RST_N = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort err", 64'(err), 64'd0);
`ifdef RELPRIME_CYCLES_EN
        check("abort cycles", 64'(cycles), 64'd0);
`endif
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (done || busy) dones++;
        end
        check("abort no_done", 64'(dones), 64'd0);
        run_and_check("after_abort", 16'd9, 16'd2, 1'b0);

        // Random operands against the model
        for (int i = 0; i < 20; i++) begin
            rv = WIDTH'($urandom_range(0, 255));
            run_and_check($sformatf("rand[%0d]", i), rv,
                          WIDTH'(model_result(32'(rv))), (rv == '0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/relprime_engine.md
# relprime_engine

Parametrised successor to the single-width relprime datapath. On a `start` pulse it finds the smallest integer `m >= 2` with `gcd(n, m) == 1` for a `WIDTH`-bit input `n`. It runs a subtraction-based Euclid FSM and exposes a `busy`/`done` handshake. The constants 1 and 2 that previously came in on ports are internal, and zero input is reported explicitly as an error. The block sits under the top level as the compute core driven by the register-file value.

## Interface
- `WIDTH`, default 16: operand and result width in bits; legal range 4..32.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in `IDLE`.
- `n`  in  `WIDTH`  operand; latched on the accepted start.
- `busy`  out  1  high while a computation is in progress.
- `done`  out  1  one-cycle pulse when `result`/`err` are valid.
- `result`  out  `WIDTH`  smallest coprime `m`; held until the next accepted start.
- `err`  out  1  high with `done` when `n == 0`; held like `result`.
- `cycles`  out  32  present only with `RELPRIME_CYCLES_EN` (see Configuration).

## Operation
- State machine: `IDLE` -> `GCD` -> `DONE` -> `IDLE`.
- Internal registers: `n_q`, `a`, `b`, `m`, all `WIDTH` bits.
- `IDLE`, `start == 1`, `n != 0`:
  - `n_q <= n`, `a <= n`, `b <= 2`, `m <= 2`, `err <= 0`.
  - Go to `GCD`.
- `IDLE`, `start == 1`, `n == 0`:
  - `result <= 0`, `err <= 1`.
  - Go straight to `DONE`.
- `GCD`, one step per cycle, in this priority order:
  - If `b == 0` and `a == 1`: `result <= m`, go to `DONE`.
  - If `b == 0` and `a != 1`: `m <= m + 1`, `a <= n_q`, `b <= m + 1`, stay in `GCD`.
  - Else if `a >= b`: `a <= a - b`.
  - Else swap: `a <= b`, `b <= a`.
- `DONE`: `done = 1` for this cycle only, then go to `IDLE`.
- `busy = 1` exactly when the state is `GCD`.
- Arithmetic is unsigned and `WIDTH` bits wide. Subtraction never underflows because it is guarded by `a >= b`.
- `m` cannot overflow:
  - For `n >= 1`, `n + 1` is always coprime.
  - For `n = 2^WIDTH - 1`, `n` is odd, so the answer is 2.
- `start` while `busy` or in `DONE` is ignored; it is neither queued nor a restart.
- Changes on `n` after acceptance have no effect.
- Special case `n == 1`: result 2.

## Timing
- Reset values: state `IDLE`, `busy = 0`, `done = 0`, `result = 0`, `err = 0`, internal registers 0.
- Reset asserted mid-operation aborts immediately, returns to `IDLE` and produces no `done` pulse.
- Start accepted at edge k:
  - `busy` is high from edge k.
  - `done` rises at the edge after the terminating `GCD` step.
  - `busy` falls at the same edge `done` rises.
- `n == 0`: `done` is high for the cycle after the accepting edge, and `busy` never rises.
- Latency is data-dependent: the sum over candidates `m` of the Euclid step count plus one reload cycle each.
- Example: `n = 6`, `m = 5` gives (6,5)->(1,5)->(5,1)->...->(0,1)->(1,0).
- A new `start` is accepted in the first `IDLE` cycle after `done`, i.e. the earliest back-to-back restart is 2 cycles after `done` rises.

## Configuration
- `RELPRIME_CYCLES_EN` defined:
  - Adds the 32-bit `cycles` output.
  - `cycles` clears to 0 on an accepted start, increments every `GCD` cycle and saturates at `0xFFFF_FFFF`.
  - Its value is held from `done` until the next start; it resets to 0.
- `RELPRIME_CYCLES_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- `WIDTH = 16`, `n = 42000`, one-cycle `start` after reset release -> exactly one `done` pulse, `result = 11`, `err = 0`; `busy` is high continuously until `done`.
- `n = 30`, then `n = 1`, then `n = 65535`, each started after the previous `done` -> `result` = 7, 2, 2 respectively.
- `n = 0` -> `done` one cycle after start, `err = 1`, `result = 0`, `busy` stays 0.
- `n = 42000`; pulse `start` again with `n = 30` while `busy` -> second request ignored, `result = 11`, a single `done`.
- `n = 42000`; drop `RST_N` 5 cycles into `GCD` -> outputs 0 asynchronously, no `done`. After release, `n = 9` -> `result = 2`.
- `RELPRIME_CYCLES_EN` defined, `n = 6` -> `result = 5` and `cycles` equals the bench-model count of `GCD` cycles; `WIDTH = 32`, `n = 0xFFFFFFFF` -> `result = 2`.
